logic_pipe_unit: RTL and testbench

- Parametrised successor to the two-input gate top level. Combines operand buses pi_a and pi_b with a run-time selectable operation (AND/OR/XOR/ADD).
- The result travels through a configurable-depth register pipeline with a valid/ready handshake.
- Also keeps a saturating count of delivered results.
- Sits between stimulus/source logic and any downstream consumer that may apply backpressure.

---
 rtl/logic_pipe_unit.sv | 116 +++++++++++
 tb/tb_logic_pipe_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/logic_pipe_unit.sv
// Operand combiner (AND/OR/XOR/ADD) feeding a STAGES-deep valid/ready pipeline with a saturating delivery counter.
// Optional macro LOGIC_PIPE_PARITY_EN adds a per-stage parity bit; otherwise po_parity is tied low.
module logic_pipe_unit #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pi_a,
    input  logic [WIDTH-1:0] pi_b,
    input  logic [1:0]       pi_op,
    input  logic             pi_valid,
    output logic             pi_ready,
    output logic [WIDTH-1:0] po_c,
    output logic             po_carry,
    output logic             po_parity,
    output logic             po_valid,
    input  logic             po_ready,
    output logic [CNT_W-1:0] po_cnt
);

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_ADD = 2'b11
    } op_e;

    logic [WIDTH-1:0] r_data  [STAGES];
    logic             r_carry [STAGES];
    logic             r_valid [STAGES];
    logic [CNT_W-1:0] r_cnt;

    logic             w_en;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;

    // Global stall: the whole pipe freezes while the last stage holds an unaccepted beat.
    assign w_en     = ~r_valid[STAGES-1] | po_ready;
    assign pi_ready = w_en;
    assign w_sum    = {1'b0, pi_a} + {1'b0, pi_b};

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        case (op_e'(pi_op))
            OP_AND: w_res = pi_a & pi_b;
            OP_OR:  w_res = pi_a | pi_b;
            OP_XOR: w_res = pi_a ^ pi_b;
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            default: w_res = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so each stage samples its
    // predecessor's pre-edge value; data registers are reset too so outputs read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                r_data[s]  <= '0;
                r_carry[s] <= 1'b0;
                r_valid[s] <= 1'b0;
            end
        end else if (w_en) begin
            r_data[0]  <= w_res;
            r_carry[0] <= w_carry;
            r_valid[0] <= pi_valid;
            for (int s = 1; s < STAGES; s++) begin
                r_data[s]  <= r_data[s-1];
                r_carry[s] <= r_carry[s-1];
                r_valid[s] <= r_valid[s-1];
            end
        end
    end

`ifdef LOGIC_PIPE_PARITY_EN
    logic r_par [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                r_par[s] <= 1'b0;
            end
        end else if (w_en) begin
            r_par[0] <= ^w_res;
            for (int s = 1; s < STAGES; s++) begin
                r_par[s] <= r_par[s-1];
            end
        end
    end

    assign po_parity = r_par[STAGES-1];
`else
    assign po_parity = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_valid[STAGES-1] && po_ready && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign po_c     = r_data[STAGES-1];
    assign po_carry = r_carry[STAGES-1];
    assign po_valid = r_valid[STAGES-1];
    assign po_cnt   = r_cnt;

endmodule

// File: tb/tb_logic_pipe_unit.sv
// Directed bench for logic_pipe_unit: reset, op table, consecutive issue, backpressure and counter saturation.
module tb_logic_pipe_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pi_a, pi_b;
    logic [1:0]  pi_op;
    logic        pi_valid;
    logic        pi_ready, s_pi_ready;
    logic [7:0]  po_c, s_po_c;
    logic        po_carry, s_po_carry;
    logic        po_parity, s_po_parity;
    logic        po_valid, s_po_valid;
    logic        po_ready;
    logic [15:0] po_cnt;
    logic [2:0]  s_po_cnt;

    always #5 clk = ~clk;

    logic_pipe_unit #(.WIDTH(8), .STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .pi_a(pi_a), .pi_b(pi_b), .pi_op(pi_op),
        .pi_valid(pi_valid), .pi_ready(pi_ready), .po_c(po_c), .po_carry(po_carry),
        .po_parity(po_parity), .po_valid(po_valid), .po_ready(po_ready), .po_cnt(po_cnt)
    );

    logic_pipe_unit #(.WIDTH(8), .STAGES(2), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .pi_a(pi_a), .pi_b(pi_b), .pi_op(pi_op),
        .pi_valid(pi_valid), .pi_ready(s_pi_ready), .po_c(s_po_c), .po_carry(s_po_carry),
        .po_parity(s_po_parity), .po_valid(s_po_valid), .po_ready(po_ready), .po_cnt(s_po_cnt)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] c;
        logic       carry;
    } vec_t;

    vec_t tbl [10];
    vec_t bp  [5];
    int   checks   = 0;
    int   failures = 0;
    int   in_idx, out_idx;
    logic in_x;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_par(input logic [7:0] c);
`ifdef LOGIC_PIPE_PARITY_EN
        return ^c;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        tbl[0] = '{8'hF0, 8'h3C, 2'b00, 8'h30, 1'b0};
        tbl[1] = '{8'hF0, 8'h3C, 2'b01, 8'hFC, 1'b0};
        tbl[2] = '{8'hF0, 8'h3C, 2'b10, 8'hCC, 1'b0};
        tbl[3] = '{8'hFF, 8'h02, 2'b11, 8'h01, 1'b1};
        tbl[4] = '{8'h10, 8'h20, 2'b11, 8'h30, 1'b0};
        tbl[5] = '{8'h07, 8'h00, 2'b01, 8'h07, 1'b0};
        tbl[6] = '{8'h80, 8'h7F, 2'b11, 8'hFF, 1'b0};
        tbl[7] = '{8'hFF, 8'hFF, 2'b00, 8'hFF, 1'b0};
        tbl[8] = '{8'hAA, 8'hAA, 2'b10, 8'h00, 1'b0};
        tbl[9] = '{8'hFF, 8'hFF, 2'b11, 8'hFE, 1'b1};

        bp[0] = '{8'h11, 8'h22, 2'b11, 8'h33, 1'b0};
        bp[1] = '{8'hAA, 8'h0F, 2'b00, 8'h0A, 1'b0};
        bp[2] = '{8'h80, 8'h80, 2'b11, 8'h00, 1'b1};
        bp[3] = '{8'h55, 8'hFF, 2'b10, 8'hAA, 1'b0};
        bp[4] = '{8'h01, 8'h80, 2'b01, 8'h81, 1'b0};

        // Reset held with a valid beat presented: nothing may leak through.
        rst = 1'b1; pi_valid = 1'b1; pi_a = 8'h01; pi_b = 8'h02; pi_op = 2'b11; po_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_valid", po_valid, 0);
            check("rst_c", po_c, 0);
            check("rst_cnt", po_cnt, 0);
        end
        check("rst_carry", po_carry, 0);
        check("rst_parity", po_parity, 0);
        rst = 1'b0;
        tick();
        check("first_lat_1", po_valid, 0);
        pi_valid = 1'b0;
        tick();
        check("first_lat_2_valid", po_valid, 1);
        check("first_lat_2_c", po_c, 8'h03);

        // Three ops on consecutive cycles; results on cycles 2, 3, 4.
        for (int k = 0; k < 6; k++) begin
            if (k < 3) begin
                pi_a = 8'hF0; pi_b = 8'h3C; pi_op = 2'(k); pi_valid = 1'b1;
            end else begin
                pi_valid = 1'b0;
            end
            case (k)
                1: check("seq_c1_valid", po_valid, 0);
                2: begin check("seq_and", po_c, 8'h30); check("seq_and_v", po_valid, 1); end
                3: begin check("seq_or", po_c, 8'hFC); check("seq_or_cy", po_carry, 0); end
                4: begin check("seq_xor", po_c, 8'hCC); check("seq_xor_v", po_valid, 1); end
                5: check("seq_drain", po_valid, 0);
                default: ;
            endcase
            tick();
        end

        // Table: one beat followed by a bubble, result checked after STAGES edges.
        for (int i = 0; i < 10; i++) begin
            pi_a = tbl[i].a; pi_b = tbl[i].b; pi_op = tbl[i].op; pi_valid = 1'b1;
            check($sformatf("tbl%0d_ready", i), pi_ready, 1);
            tick();
            pi_valid = 1'b0;
            tick();
            check($sformatf("tbl%0d_valid", i), po_valid, 1);
            check($sformatf("tbl%0d_c", i), po_c, tbl[i].c);
            check($sformatf("tbl%0d_carry", i), po_carry, tbl[i].carry);
            check($sformatf("tbl%0d_parity", i), po_parity, exp_par(tbl[i].c));
        end
        tick();
        check("tbl_bubble", po_valid, 0);
        check("tbl_cnt", po_cnt, 14);

        // Backpressure: 5 beats, po_ready low for 4 cycles while an output is pending.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("bp_rst_cnt", po_cnt, 0);
        in_idx = 0; out_idx = 0;
        for (int c = 0; c < 40 && out_idx < 5; c++) begin
            po_ready = !(c >= 3 && c <= 6);
            if (in_idx < 5) begin
                pi_a = bp[in_idx].a; pi_b = bp[in_idx].b; pi_op = bp[in_idx].op; pi_valid = 1'b1;
            end else begin
                pi_valid = 1'b0;
            end
            #1;
            in_x = pi_valid && pi_ready;
            if (po_valid && !po_ready) begin
                check("bp_stall_ready", pi_ready, 0);
                check("bp_hold_c", po_c, bp[out_idx].c);
                check("bp_hold_carry", po_carry, bp[out_idx].carry);
                check("bp_hold_parity", po_parity, exp_par(bp[out_idx].c));
            end
            if (po_valid && po_ready) begin
                check($sformatf("bp_out%0d_c", out_idx), po_c, bp[out_idx].c);
                check($sformatf("bp_out%0d_carry", out_idx), po_carry, bp[out_idx].carry);
                out_idx++;
            end
            tick();
            if (in_x) in_idx++;
        end
        pi_valid = 1'b0; po_ready = 1'b1;
        check("bp_delivered", out_idx, 5);
        check("bp_cnt", po_cnt, 5);
        tick();
        check("bp_no_dup", po_valid, 0);

        // Saturation: 10 back-to-back beats; CNT_W=3 instance must stop at 7.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pi_a = 8'(i); pi_b = 8'h00; pi_op = 2'b01; pi_valid = 1'b1;
            tick();
        end
        pi_valid = 1'b0;
        repeat (3) tick();
        check("sat_cnt3", s_po_cnt, 7);
        check("sat_cnt16", po_cnt, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
